// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM for the multicycle RV32I core
module multicycle_control #(
    parameter int INSTRET_WIDTH   = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     zero,
    input  logic                     mem_ready,
    output logic                     pc_write,
    output logic                     ir_write,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     i_or_d,
    output logic                     reg_write,
    output logic [1:0]               mem_to_reg,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               aluop,
    output logic                     pc_source,
    output logic                     illegal_instr,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic [3:0]               state
);
    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC_R    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_EXEC_I    = 4'd11,
        ST_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t                   state_q, state_d;
    logic                     mem_read_q, mem_read_d;
    logic                     mem_write_q, mem_write_d;
    logic                     i_or_d_q, i_or_d_d;
    logic                     reg_write_q, reg_write_d;
    logic [1:0]               mem_to_reg_q, mem_to_reg_d;
    logic [1:0]               alu_src_a_q, alu_src_a_d;
    logic [1:0]               alu_src_b_q, alu_src_b_d;
    logic [1:0]               aluop_q, aluop_d;
    logic                     pc_source_q, pc_source_d;
    logic                     illegal_q, illegal_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    logic                     retire;

    // next-state sequencing; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:     state_d = ST_FETCH;
            ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:    state_d = (opcode == OP_R)                      ? ST_EXEC_R   :
                                    (opcode == OP_I)                      ? ST_EXEC_I   :
                                    (opcode == OP_LD || opcode == OP_ST)  ? ST_MEM_ADDR :
                                    (opcode == OP_BR)                     ? ST_BRANCH   :
                                    (opcode == OP_JAL)                    ? ST_JAL      :
                                    TRAP_ON_ILLEGAL                       ? ST_TRAP     : ST_FETCH;
            ST_MEM_ADDR:  state_d = (opcode == OP_ST) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC_R,
            ST_EXEC_I:    state_d = ST_ALU_WB;
            ST_MEM_WB,
            ST_ALU_WB,
            ST_BRANCH,
            ST_JAL:       state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_RESET;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they come out of flops
    always_comb begin
        mem_read_d   = state_d == ST_FETCH || state_d == ST_MEM_READ;
        mem_write_d  = state_d == ST_MEM_WRITE;
        i_or_d_d     = state_d == ST_MEM_READ || state_d == ST_MEM_WRITE;
        reg_write_d  = state_d == ST_MEM_WB || state_d == ST_ALU_WB || state_d == ST_JAL;
        mem_to_reg_d = (state_d == ST_MEM_WB) ? 2'b01 : (state_d == ST_JAL) ? 2'b10 : 2'b00;
        alu_src_a_d  = (state_d == ST_DECODE) ? 2'b10 :
                       (state_d == ST_MEM_ADDR || state_d == ST_EXEC_R ||
                        state_d == ST_EXEC_I || state_d == ST_BRANCH) ? 2'b01 : 2'b00;
        alu_src_b_d  = (state_d == ST_FETCH) ? 2'b01 :
                       (state_d == ST_DECODE || state_d == ST_MEM_ADDR ||
                        state_d == ST_EXEC_I) ? 2'b10 : 2'b00;
        aluop_d      = (state_d == ST_EXEC_R || state_d == ST_EXEC_I) ? 2'b10 :
                       (state_d == ST_BRANCH) ? 2'b01 : 2'b00;
        pc_source_d  = state_d == ST_BRANCH || state_d == ST_JAL;
        illegal_d    = state_d == ST_TRAP;
    end

    // an instruction retires on the edge that ends its final state
    always_comb begin
        retire    = state_q == ST_MEM_WB || state_q == ST_ALU_WB || state_q == ST_BRANCH ||
                    state_q == ST_JAL || (state_q == ST_MEM_WRITE && mem_ready);
        instret_d = retire ? instret_q + INSTRET_WIDTH'(1) : instret_q;
    end

    // state, registered outputs and retire counter; reset drops everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RESET;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            i_or_d_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 2'b00;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b00;
            aluop_q      <= 2'b00;
            pc_source_q  <= 1'b0;
            illegal_q    <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            i_or_d_q     <= i_or_d_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            aluop_q      <= aluop_d;
            pc_source_q  <= pc_source_d;
            illegal_q    <= illegal_d;
            instret_q    <= instret_d;
        end
    end

    // handshake-qualified enables react within the cycle
    always_comb begin
        ir_write = state_q == ST_FETCH && mem_ready;
        pc_write = (state_q == ST_FETCH && mem_ready) || (state_q == ST_BRANCH && zero) ||
                   state_q == ST_JAL;
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign i_or_d        = i_or_d_q;
    assign reg_write     = reg_write_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign alu_src_a     = alu_src_a_q;
    assign alu_src_b     = alu_src_b_q;
    assign aluop         = aluop_q;
    assign pc_source     = pc_source_q;
    assign illegal_instr = illegal_q;
    assign instret       = instret_q;
    assign state         = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle sequencing FSM
module tb_multicycle_control;
    // outputs packed as {pw, irw, mr, mw, iod, rw, m2r[2], a[2], b[2], op[2], ps, ill}
    localparam logic [15:0] O_ZERO    = 16'b0_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] O_FETCH   = 16'b1_1_1_0_0_0_00_00_01_00_0_0;
    localparam logic [15:0] O_DECODE  = 16'b0_0_0_0_0_0_00_10_10_00_0_0;
    localparam logic [15:0] O_EXEC_R  = 16'b0_0_0_0_0_0_00_01_00_10_0_0;
    localparam logic [15:0] O_ALU_WB  = 16'b0_0_0_0_0_1_00_00_00_00_0_0;
    localparam logic [15:0] O_MADDR   = 16'b0_0_0_0_0_0_00_01_10_00_0_0;
    localparam logic [15:0] O_MREAD   = 16'b0_0_1_0_1_0_00_00_00_00_0_0;
    localparam logic [15:0] O_MEM_WB  = 16'b0_0_0_0_0_1_01_00_00_00_0_0;
    localparam logic [15:0] O_MWRITE  = 16'b0_0_0_1_1_0_00_00_00_00_0_0;
    localparam logic [15:0] O_BR_T    = 16'b1_0_0_0_0_0_00_01_00_01_1_0;
    localparam logic [15:0] O_BR_N    = 16'b0_0_0_0_0_0_00_01_00_01_1_0;
    localparam logic [15:0] O_JAL     = 16'b1_0_0_0_0_1_10_00_00_00_1_0;
    localparam logic [15:0] O_TRAP    = 16'b0_0_0_0_0_0_00_00_00_00_0_1;
    localparam logic [6:0]  OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0]  OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

    logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [6:0] opcode = OP_R;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, pc_source, illegal_instr;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, aluop;
    logic [3:0] instret, state;
    logic       reset_n = 1'b1;
    logic [6:0] opcode_n = OP_BAD;
    logic       n_pw, n_irw, n_mr, n_mw, n_iod, n_rw, n_ps, n_ill;
    logic [1:0] n_m2r, n_a, n_b, n_op;
    logic [7:0] n_instret;
    logic [3:0] n_state;
    int         n_chk = 0, n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control #(.INSTRET_WIDTH(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .aluop(aluop), .pc_source(pc_source),
        .illegal_instr(illegal_instr), .instret(instret), .state(state)
    );

    multicycle_control #(.INSTRET_WIDTH(8), .TRAP_ON_ILLEGAL(1'b0)) dut_n (
        .clk(clk), .reset(reset_n), .opcode(opcode_n), .zero(1'b0), .mem_ready(1'b1),
        .pc_write(n_pw), .ir_write(n_irw), .mem_read(n_mr), .mem_write(n_mw),
        .i_or_d(n_iod), .reg_write(n_rw), .mem_to_reg(n_m2r), .alu_src_a(n_a),
        .alu_src_b(n_b), .aluop(n_op), .pc_source(n_ps),
        .illegal_instr(n_ill), .instret(n_instret), .state(n_state)
    );

    function automatic logic [15:0] outs();
        return {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                mem_to_reg, alu_src_a, alu_src_b, aluop, pc_source, illegal_instr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] o);
        tick();
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".outs"}, 32'(outs()), 32'(o));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst.state", 32'(state), 0);
        chk("rst.outs", 32'(outs()), 32'(O_ZERO));
        chk("rst.instret", 32'(instret), 0);
        reset = 1'b0;
        step("r.fetch", 4'd1, O_FETCH);
        step("r.decode", 4'd2, O_DECODE);
        step("r.exec", 4'd7, O_EXEC_R);
        step("r.wb", 4'd8, O_ALU_WB);
        chk("r.instret_pre", 32'(instret), 0);
        step("r.next", 4'd1, O_FETCH);
        chk("r.instret", 32'(instret), 1);

        opcode = OP_LD;
        step("ld.decode", 4'd2, O_DECODE);
        step("ld.addr", 4'd3, O_MADDR);
        mem_ready = 1'b0;
        step("ld.wait0", 4'd4, O_MREAD);
        step("ld.wait1", 4'd4, O_MREAD);
        step("ld.wait2", 4'd4, O_MREAD);
        step("ld.wait3", 4'd4, O_MREAD);
        mem_ready = 1'b1;
        step("ld.wb", 4'd5, O_MEM_WB);
        step("ld.next", 4'd1, O_FETCH);
        chk("ld.instret", 32'(instret), 2);

        opcode = OP_BR;
        zero = 1'b1;
        step("bt.decode", 4'd2, O_DECODE);
        step("bt.branch", 4'd9, O_BR_T);
        step("bt.next", 4'd1, O_FETCH);
        chk("bt.instret", 32'(instret), 3);
        zero = 1'b0;
        step("bn.decode", 4'd2, O_DECODE);
        step("bn.branch", 4'd9, O_BR_N);
        step("bn.next", 4'd1, O_FETCH);
        chk("bn.instret", 32'(instret), 4);

        opcode = OP_JAL;
        step("jal.decode", 4'd2, O_DECODE);
        step("jal.exec", 4'd10, O_JAL);
        step("jal.next", 4'd1, O_FETCH);
        chk("jal.instret", 32'(instret), 5);

        opcode = OP_R;
        for (int i = 0; i < 10; i++) repeat (4) tick();
        chk("wrap.full", 32'(instret), 15);
        repeat (4) tick();
        chk("wrap.zero", 32'(instret), 0);
        repeat (4) tick();
        chk("wrap.one", 32'(instret), 1);

        opcode = OP_ST;
        step("st.decode", 4'd2, O_DECODE);
        step("st.addr", 4'd3, O_MADDR);
        step("st.write", 4'd6, O_MWRITE);
        step("st.next", 4'd1, O_FETCH);
        chk("st.instret", 32'(instret), 2);
        step("sw.decode", 4'd2, O_DECODE);
        step("sw.addr", 4'd3, O_MADDR);
        mem_ready = 1'b0;
        step("sw.wait0", 4'd6, O_MWRITE);
        step("sw.wait1", 4'd6, O_MWRITE);
        reset = 1'b1;
        #1;
        chk("arst.state", 32'(state), 0);
        chk("arst.outs", 32'(outs()), 32'(O_ZERO));
        chk("arst.instret", 32'(instret), 0);

        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        opcode = OP_BAD;
        step("trap.fetch", 4'd1, O_FETCH);
        step("trap.decode", 4'd2, O_DECODE);
        for (int i = 0; i < 20; i++) step("trap.hold", 4'd15, O_TRAP);
        chk("trap.instret", 32'(instret), 0);

        reset_n = 1'b0;
        tick();
        chk("drop.fetch", 32'(n_state), 1);
        tick();
        chk("drop.decode", 32'(n_state), 2);
        tick();
        chk("drop.back", 32'(n_state), 1);
        chk("drop.ill", 32'(n_ill), 0);
        chk("drop.instret", 32'(n_instret), 0);
        opcode_n = OP_R;
        repeat (4) tick();
        chk("drop.r_instret", 32'(n_instret), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
